rr_beat_arbiter: RTL and testbench
==================================

Name: rr_beat_arbiter

Overview:
- N-channel round-robin arbiter that merges valid/ready request streams into one registered output stream toward the cache/AXI master port.
- Generalises the two-channel read/write arbiter: arbitrary channel count and data width, multi-beat packet locking, and a registered output stage with a channel ID tag.
- Channel 0 is the read path and channel 1 is the write path when NUM_CH=2.

Parameters:
NUM_CH, 2, number of requesting channels (>=2)
DATA_W, 64, payload width per channel
ID_W, $clog2(NUM_CH), width of the output channel tag (derived, not overridden)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
in_valid  input  NUM_CH  per-channel request valid
in_data  input  NUM_CH*DATA_W  packed payloads; channel i is bits [i*DATA_W +: DATA_W]
in_last  input  NUM_CH  per-channel last beat of packet
in_ready  output  NUM_CH  per-channel accept
out_valid  output  1  output beat valid
out_data  output  DATA_W  output payload
out_last  output  1  output last beat
out_id  output  ID_W  source channel of the output beat
out_ready  input  1  downstream accept

Behaviour:
- Reset: out_valid=0, out_data=0, out_last=0, out_id=0, in_ready=0. State=ARB. last_served=NUM_CH-1, so channel 0 has first priority.
- Transfers: an input beat transfers when in_valid[i]&&in_ready[i]. An output beat transfers when out_valid&&out_ready.
- Slot free: a cycle is slot-free when !out_valid || out_ready.
- in_ready[i]: in_ready[i] = slot_free && (grant==i) && in_valid[i], with grant computed combinationally. At most one in_ready bit is high per cycle.
- ARB grant: first channel with in_valid set, searching upward from last_served+1 modulo NUM_CH.
  - A single requester always wins.
  - No requester: no grant, and last_served is unchanged.
- LOCKED grant: grant is held at locked_ch. No other channel gets ready, even if locked_ch drops valid.
- Transitions:
  - ARB -> LOCKED on an accepted beat with in_last=0. locked_ch is set to that channel.
  - LOCKED -> ARB on an accepted beat of locked_ch with in_last=1.
  - ARB -> ARB on an accepted single-beat packet (in_last=1).
- last_served updates on each accepted in_last=1 beat only. Round-robin fairness is therefore per packet, not per beat.
- Output register: loaded on each accepted input beat with data, last and id.
  - out_valid is set on load and cleared when an output transfer happens without a new load in the same cycle.
  - Latency is 1 cycle from input acceptance to out_valid.
  - Throughput is 1 beat/cycle while out_ready=1.
- Backpressure:
  - While out_valid && !out_ready, the output register holds and all in_ready=0.
  - The out_* signals stay stable until accepted.
- Simultaneous output drain and new input accept in one cycle: the register is overwritten and out_valid stays 1.
- Producers keep in_valid/in_data stable until accepted (AXI rule). The arbiter does not check this.
- Reset mid-packet: the lock is dropped, any buffered beat is discarded, and the reset values above apply.
- Width rules:
  - Pointer increment wraps at NUM_CH, including non-power-of-two NUM_CH.
  - out_id is zero-extended from the channel index.

Decomposition:
- Package rr_arb_pkg: state enum (ARB, LOCKED) and a helper function for the wrap-around increment of the channel index.
- One sub-module, rr_prio_pick: purely combinational round-robin picker.
  - Inputs: request vector and last_served.
  - Outputs: one-hot grant, grant index, and any-valid.
- Everything else lives in rr_beat_arbiter: FSM, lock register, last_served, output register.

Test Plan:
- NUM_CH=2, both channels valid with single-beat packets, out_ready=1 for 6 cycles.
  - out_id sequence is 0,1,0,1,0,1.
  - out_valid is first seen 1 cycle after the first accept.
- NUM_CH=2, only ch1 valid for 4 single beats.
  - out_id is 1,1,1,1 with no bubbles.
  - last_served stays at 1, so a subsequent dual request grants ch0.
- NUM_CH=4, ch2 sends a 3-beat packet (last on beat 3) while ch0/ch3 are valid.
  - 3 consecutive id=2 beats, then id=3, then id=0.
  - ch2 drops valid between beats 1 and 2: the lock holds and no other channel is granted.
- out_ready=0 for 5 cycles with ch0 data 0xA5.
  - out_data=0xA5 is held stable and all in_ready=0.
  - On the out_ready rising edge, the beat transfers and the next beat loads in the same cycle.
- NUM_CH=3 wrap check: requests on all channels over 7 packets give id 0,1,2,0,1,2,0.
- Assert rst mid-packet (ch1 locked, out_valid=1).
  - Next cycle: out_valid=0, state=ARB.
  - After release with all valid: ch0 is granted first.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin beat arbiter.
//   arb_state_e : arbitration FSM states (free arbitration / packet locked)
//   wrap_inc    : channel index increment that wraps at the channel count
package rr_arb_pkg;

  typedef enum logic [0:0] {
    StArb,
    StLocked
  } arb_state_e;

  // Works for any channel count, including non-powers of two.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin picker.
//   req         : per-channel request vector
//   last_served : channel that most recently finished a packet
//   grant_oh    : one-hot grant, first requester above last_served (wrapping)
//   grant_idx   : index of the granted channel
//   any_valid   : at least one channel is requesting
module rr_prio_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  localparam int unsigned ID_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   last_served,
  output logic [NUM_CH-1:0] grant_oh,
  output logic [ID_W-1:0]   grant_idx,
  output logic              any_valid
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    idx       = ID_W'(wrap_inc(32'(last_served), NUM_CH));
    for (int k = 0; k < NUM_CH; k++) begin
      if (!any_valid && req[idx]) begin
        any_valid     = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = idx;
      end
      idx = ID_W'(wrap_inc(32'(idx), NUM_CH));
    end
  end

endmodule

// File: rtl/rr_beat_arbiter.sv
// N-channel round-robin arbiter merging valid/ready streams into one registered
// output stream. Multi-beat packets lock the grant until their last beat, and
// fairness advances per packet.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/data/last   : per-channel request streams (data packed per channel)
//   in_ready             : per-channel accept, at most one bit high
//   out_valid/data/last  : registered output beat
//   out_id               : source channel of the output beat
//   out_ready            : downstream accept
module rr_beat_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 64,
  localparam int unsigned ID_W = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [ID_W-1:0]          out_id,
  input  logic                     out_ready
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] locked_q, locked_d;
  logic [ID_W-1:0] last_q, last_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;

  logic [NUM_CH-1:0] pick_oh;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;

  logic [NUM_CH-1:0] grant_oh;
  logic [ID_W-1:0]   grant_idx;
  logic              slot_free;
  logic              accept;

  logic [DATA_W-1:0] ch_data [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_data[g] = in_data[g*DATA_W +: DATA_W];
  end

  rr_prio_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .req         (in_valid),
    .last_served (last_q),
    .grant_oh    (pick_oh),
    .grant_idx   (pick_idx),
    .any_valid   (pick_any)
  );

  assign slot_free = !out_valid_q || out_ready;
  assign accept    = |in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StArb;
      locked_q    <= '0;
      last_q      <= ID_W'(NUM_CH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      locked_q    <= locked_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_id_q    <= out_id_d;
    end
  end

  // Next-state: lock on a non-last beat, release and advance fairness on a last beat
  always_comb begin
    state_d     = state_q;
    locked_d    = locked_q;
    last_d      = last_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_id_d    = out_id_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[grant_idx];
      out_last_d  = in_last[grant_idx];
      out_id_d    = grant_idx;
      unique case (state_q)
        StArb: begin
          if (in_last[grant_idx]) begin
            last_d = grant_idx;
          end else begin
            state_d  = StLocked;
            locked_d = grant_idx;
          end
        end
        StLocked: begin
          if (in_last[grant_idx]) begin
            state_d = StArb;
            last_d  = grant_idx;
          end
        end
        default: state_d = StArb;
      endcase
    end
  end

  // Outputs: grant selection and per-channel ready
  always_comb begin
    grant_oh  = pick_any ? pick_oh : '0;
    grant_idx = pick_idx;
    if (state_q == StLocked) begin
      // Held even if the locked channel drops valid mid-packet
      grant_oh  = NUM_CH'(1) << locked_q;
      grant_idx = locked_q;
    end
    in_ready = '0;
    if (!rst && slot_free) begin
      in_ready = grant_oh & in_valid;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_rr_beat_arbiter.sv
module tb_rr_beat_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Two-channel instance
  logic [1:0]  v2, l2, rdy2;
  logic [15:0] d2;
  logic        ov2, ol2, or2;
  logic [7:0]  od2;
  logic [0:0]  oi2;

  // Four-channel instance
  logic [3:0]  v4, l4, rdy4;
  logic [31:0] d4;
  logic        ov4, ol4, or4;
  logic [7:0]  od4;
  logic [1:0]  oi4;

  // Three-channel instance
  logic [2:0]  v3, l3, rdy3;
  logic [23:0] d3;
  logic        ov3, ol3, or3;
  logic [7:0]  od3;
  logic [1:0]  oi3;

  rr_beat_arbiter #(.NUM_CH(2), .DATA_W(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2), .in_last(l2), .in_ready(rdy2),
    .out_valid(ov2), .out_data(od2), .out_last(ol2), .out_id(oi2), .out_ready(or2)
  );

  rr_beat_arbiter #(.NUM_CH(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .in_last(l4), .in_ready(rdy4),
    .out_valid(ov4), .out_data(od4), .out_last(ol4), .out_id(oi4), .out_ready(or4)
  );

  rr_beat_arbiter #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_data(d3), .in_last(l3), .in_ready(rdy3),
    .out_valid(ov3), .out_data(od3), .out_last(ol3), .out_id(oi3), .out_ready(or3)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    v2 = '0; l2 = '0; d2 = '0; or2 = 1'b1;
    v4 = '0; l4 = '0; d4 = '0; or4 = 1'b1;
    v3 = '0; l3 = '0; d3 = '0; or3 = 1'b1;
    tick();
    tick();

    // Reset values
    check_eq("rst_ov2", 32'(ov2), 0);
    check_eq("rst_od2", 32'(od2), 0);
    check_eq("rst_ol2", 32'(ol2), 0);
    check_eq("rst_oi2", 32'(oi2), 0);
    check_eq("rst_ov4", 32'(ov4), 0);
    check_eq("rst_ov3", 32'(ov3), 0);
    rst = 1'b0;

    // Two channels alternating single beats
    v2 = 2'b11; l2 = 2'b11; d2 = {8'h11, 8'h10};
    #1;
    check_eq("t1_ready_first", 32'(rdy2), 32'b01);
    check_eq("t1_no_early_valid", 32'(ov2), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("t1_valid", 32'(ov2), 1);
      check_eq("t1_id", 32'(oi2), i % 2);
      check_eq("t1_data", 32'(od2), 32'h10 + i % 2);
    end

    // Only channel 1 requesting: back-to-back, no bubbles
    v2 = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t2_valid", 32'(ov2), 1);
      check_eq("t2_id", 32'(oi2), 1);
    end
    v2 = 2'b11;
    #1;
    check_eq("t2_dual_grant", 32'(rdy2), 32'b01);
    tick();
    check_eq("t2_dual_id", 32'(oi2), 0);
    v2 = 2'b00;
    tick();
    check_eq("t2_drain", 32'(ov2), 0);

    // Four channels: 3-beat packet on ch2 with a mid-packet valid drop
    v4 = 4'b0100; l4 = 4'b0000; d4[23:16] = 8'h21;
    #1;
    check_eq("t3_ready_b1", 32'(rdy4), 32'b0100);
    tick();
    check_eq("t3_id_b1", 32'(oi4), 2);
    check_eq("t3_data_b1", 32'(od4), 32'h21);
    check_eq("t3_last_b1", 32'(ol4), 0);
    v4 = 4'b1001; l4 = 4'b1001; d4[7:0] = 8'h01; d4[31:24] = 8'h31;
    #1;
    check_eq("t3_lock_hold", 32'(rdy4), 0);
    tick();
    check_eq("t3_bubble", 32'(ov4), 0);
    v4 = 4'b1101; d4[23:16] = 8'h22;
    #1;
    check_eq("t3_ready_b2", 32'(rdy4), 32'b0100);
    tick();
    check_eq("t3_id_b2", 32'(oi4), 2);
    check_eq("t3_data_b2", 32'(od4), 32'h22);
    d4[23:16] = 8'h23; l4[2] = 1'b1;
    tick();
    check_eq("t3_id_b3", 32'(oi4), 2);
    check_eq("t3_data_b3", 32'(od4), 32'h23);
    check_eq("t3_last_b3", 32'(ol4), 1);
    v4[2] = 1'b0;
    tick();
    check_eq("t3_id_ch3", 32'(oi4), 3);
    check_eq("t3_data_ch3", 32'(od4), 32'h31);
    v4[3] = 1'b0;
    tick();
    check_eq("t3_id_ch0", 32'(oi4), 0);
    check_eq("t3_data_ch0", 32'(od4), 32'h01);
    v4 = '0;
    tick();
    check_eq("t3_drain", 32'(ov4), 0);

    // Three channels: wrap at a non-power-of-two count
    v3 = 3'b111; l3 = 3'b111; d3 = {8'h32, 8'h31, 8'h30};
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq("t5_id", 32'(oi3), i % 3);
      check_eq("t5_data", 32'(od3), 32'h30 + i % 3);
    end
    v3 = '0;

    // Backpressure hold, then drain and reload in the same cycle
    or2 = 1'b0; v2 = 2'b01; l2 = 2'b11; d2[7:0] = 8'hA5;
    #1;
    check_eq("t4_ready_free", 32'(rdy2), 32'b01);
    tick();
    check_eq("t4_load_valid", 32'(ov2), 1);
    check_eq("t4_load_data", 32'(od2), 32'hA5);
    d2[7:0] = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      check_eq("t4_hold_valid", 32'(ov2), 1);
      check_eq("t4_hold_data", 32'(od2), 32'hA5);
      check_eq("t4_hold_ready", 32'(rdy2), 0);
      tick();
    end
    or2 = 1'b1;
    #1;
    check_eq("t4_release_ready", 32'(rdy2), 32'b01);
    tick();
    check_eq("t4_reload_valid", 32'(ov2), 1);
    check_eq("t4_reload_data", 32'(od2), 32'h5A);
    v2 = 2'b00;
    tick();
    check_eq("t4_drain", 32'(ov2), 0);

    // Reset mid-packet with ch1 locked
    v2 = 2'b10; l2 = 2'b00; d2[15:8] = 8'h77;
    tick();
    check_eq("t6_locked_valid", 32'(ov2), 1);
    check_eq("t6_locked_id", 32'(oi2), 1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_ready", 32'(rdy2), 0);
    tick();
    check_eq("t6_rst_valid", 32'(ov2), 0);
    check_eq("t6_rst_data", 32'(od2), 0);
    rst = 1'b0; v2 = 2'b11; l2 = 2'b11;
    #1;
    check_eq("t6_post_grant", 32'(rdy2), 32'b01);
    tick();
    check_eq("t6_post_valid", 32'(ov2), 1);
    check_eq("t6_post_id", 32'(oi2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
